// File: rtl/alu_div_seq_if.sv
// Request/response bundle between the core's execute stage and the sequential divider.
// The core is the master and the divider is the slave.
interface alu_div_seq_if;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/alu_div_seq.sv
// Multi-cycle unsigned 32-bit restoring divider (DIVU/REMU).
// It has no subtractor of its own: each quotient bit is one subtract on an external combinational ALU.
module alu_div_seq #(
    parameter logic [2:0] OP_SUB   = 3'b010,
    parameter logic [2:0] OP_PASSB = 3'b011,
    parameter logic [2:0] OP_IDLE  = 3'b000
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_div_seq_if.slave  bus,
    output logic [31:0]   alu_a,
    output logic [31:0]   alu_b,
    output logic [2:0]    alu_op,
    input  logic [31:0]   alu_out,
    input  logic          alu_cf,
    input  logic          alu_zf
);
    typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] r_q, r_d;
    logic [31:0] q_q, q_d;
    logic [31:0] d_q, d_d;
    logic [31:0] n_q, n_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        dbz_q, dbz_d;
    logic [31:0] trial;
    logic        take;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            n_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            n_q         <= n_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign trial = {r_q[30:0], n_q[cnt_q]};
    // A set R[31] means the 33-bit trial exceeds any divisor, so the wrapped difference is the remainder.
    assign take  = r_q[31] | ~alu_cf;

    // ALU drive depends only on state and registers, kept apart from the block that consumes the ALU flags.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_IDLE;
        case (state_q)
            CHECK: begin
                alu_b  = d_q;
                alu_op = OP_PASSB;
            end
            ITER: begin
                alu_a  = trial;
                alu_b  = d_q;
                alu_op = OP_SUB;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        n_d         = n_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    n_d     = bus.dividend;
                    d_d     = bus.divisor;
                    r_d     = '0;
                    q_d     = '0;
                    cnt_d   = 5'd31;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (alu_zf) begin
                    quotient_d  = '1;
                    remainder_d = n_q;
                    dbz_d       = 1'b1;
                    state_d     = DONE;
                end else begin
                    state_d = ITER;
                end
            end
            ITER: begin
                if (take) begin
                    r_d        = alu_out;
                    q_d[cnt_q] = 1'b1;
                end else begin
                    r_d        = trial;
                    q_d[cnt_q] = 1'b0;
                end
                if (cnt_q == 5'd0) begin
                    quotient_d  = q_d;
                    remainder_d = r_d;
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq: a behavioural ALU closes the loop and a scoreboard
// queue holds expected results and completion cycles for every accepted start.
module tb_alu_div_seq;
    logic        clk;
    logic        rst_n;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_out;
    logic        alu_cf;
    logic        alu_zf;

    alu_div_seq_if bus ();

    alu_div_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_out (alu_out),
        .alu_cf  (alu_cf),
        .alu_zf  (alu_zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_out = '0;
        alu_cf  = 1'b0;
        case (alu_op)
            3'b010: begin
                alu_out = alu_a - alu_b;
                alu_cf  = (alu_a < alu_b);
            end
            3'b011: alu_out = alu_b;
            default: ;
        endcase
        alu_zf = (alu_out == 32'd0);
    end

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Accepts a start in the cycle after the call and records the expected outcome.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        e.q          = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        e.r          = (b == 32'd0) ? a : a % b;
        e.dbz        = (b == 32'd0);
        e.done_cyc   = cyc + ((b == 32'd0) ? 2 : 34);
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic pulseIgnored(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic waitDone();
        bit seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("quotient", bus.quotient, e.q);
                checkOutput("remainder", bus.remainder, e.r);
                checkOutput("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
                checkOutput("done_cycle", cyc, e.done_cyc);
            end
        end
    end

    initial begin
        bit any_done;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset_quotient", bus.quotient, 32'd0);
        checkOutput("reset_remainder", bus.remainder, 32'd0);
        checkOutput("reset_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        checkOutput("reset_alu_op", {29'd0, alu_op}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] 100 / 7 with busy/done timing");
        applyStimulus(32'd100, 32'd7);
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            checkOutput($sformatf("busy_c%0d", c), {31'd0, bus.busy}, {31'd0, (c <= 34)});
            checkOutput($sformatf("done_c%0d", c), {31'd0, bus.done}, {31'd0, (c == 34)});
        end

        $display("[TB] divide by zero");
        applyStimulus(32'h1234, 32'd0);
        @(negedge clk);
        checkOutput("check_alu_op", {29'd0, alu_op}, 32'd3);
        waitDone();

        $display("[TB] boundary operands");
        applyStimulus(32'hFFFF_FFFF, 32'h8000_0000);
        waitDone();
        applyStimulus(32'hFFFF_FFFF, 32'd1);
        waitDone();
        applyStimulus(32'd0, 32'd13);
        waitDone();

        $display("[TB] start ignored while busy");
        applyStimulus(32'd5, 32'd9);
        repeat (8) @(posedge clk);
        pulseIgnored(32'd50, 32'd3);
        repeat (8) @(posedge clk);
        pulseIgnored(32'd50, 32'd3);
        waitDone();
        applyStimulus(32'd50, 32'd3);
        waitDone();

        $display("[TB] random operands");
        for (int k = 0; k < 4; k++) begin
            applyStimulus($urandom, (k == 0) ? $urandom : $urandom_range(1, 1000));
            waitDone();
        end

        $display("[TB] reset mid-operation");
        applyStimulus(32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("abort_quotient", bus.quotient, 32'd0);
        checkOutput("abort_remainder", bus.remainder, 32'd0);
        checkOutput("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        any_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) any_done = 1'b1;
        end
        checkOutput("abort_no_done", {31'd0, any_done}, 32'd0);

        $display("[TB] results held during next operation");
        applyStimulus(32'd100, 32'd7);
        waitDone();
        applyStimulus(32'd9, 32'd3);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 60 && !seen; k++) begin
                @(negedge clk);
                if (bus.done) begin
                    seen = 1'b1;
                end else begin
                    checkOutput("hold_quotient", bus.quotient, 32'd14);
                    checkOutput("hold_remainder", bus.remainder, 32'd2);
                end
            end
            if (!seen) checkOutput("hold_timeout", 32'd0, 32'd1);
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
